shared_mem_arbiter: RTL and testbench
=====================================

// Module: shared_mem_arbiter
// PURPOSE
//  Shares one single-port, multi-cycle unified memory between the pipelined CPU's
//  IF stage (instruction fetch) and MEM stage (load/store). Serialises accesses,
//  returns data to the owning stage and drives the per-stage stall signals that
//  freeze PC and pipeline registers. Sits between the CPU core and the memory model.
// PARAMETERS
//  ADDR_W   32   address width (byte address)
//  DATA_W   32   data width
//  TIMEOUT  64   WAIT cycles without mem_resp_valid before err is raised
// PORTS
//  clk             in   1       clock; all state on rising edge
//  reset           in   1       asynchronous, active-low reset
//  if_req          in   1       IF stage requests a fetch at if_addr
//  if_addr         in   ADDR_W  fetch address (PC)
//  if_flush        in   1       discard in-flight or pending fetch (redirect)
//  if_done         out  1       1-cycle pulse: if_rdata valid
//  if_rdata        out  DATA_W  fetched instruction
//  if_stall        out  1       IF must hold PC/IF_ID register
//  d_req           in   1       MEM stage requests a data access
//  d_we            in   1       1 = store, 0 = load
//  d_addr          in   ADDR_W  data address (ALU result)
//  d_wdata         in   DATA_W  store data
//  d_done          out  1       1-cycle pulse: access complete, d_rdata valid on load
//  d_rdata         out  DATA_W  load data
//  d_stall         out  1       MEM and all older-facing stages must hold
//  mem_req         out  1       request valid toward memory
//  mem_we          out  1       write enable of current request
//  mem_addr        out  ADDR_W  request address
//  mem_wdata       out  DATA_W  request write data
//  mem_ready       in   1       memory accepts request this cycle
//  mem_resp_valid  in   1       response (read data or write ack) this cycle
//  mem_rdata       in   DATA_W  response read data
//  err             out  1       sticky: watchdog timeout
// BEHAVIOUR
//  Reset: state IDLE; every output 0 (incl. rdata buses); owner/kill cleared; err 0.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: d_req has priority over if_req (MEM holds the older instruction). On any
//     req: latch owner, we, addr, wdata into internal regs; go ISSUE next cycle.
//     if_req with if_flush same cycle is not granted.
//   ISSUE: mem_req=1 with latched fields (stable until accepted); on mem_ready go WAIT.
//   WAIT: on mem_resp_valid capture mem_rdata into owner's rdata, pulse owner's done
//     for exactly one cycle, return IDLE. rdata holds until next response for that owner.
//  Minimum latency: req seen in IDLE -> done 3 cycles later with ready/resp immediate.
//  One-cycle IDLE bubble between transactions; no back-to-back issue.
//  Stalls (combinational): if_stall = if_req & ~if_done; d_stall = d_req & ~d_done.
//  Flush: if_flush while owner=IF in ISSUE/WAIT sets kill; transaction still completes
//    on memory but if_done suppressed and if_rdata not updated; kill cleared in IDLE.
//    if_flush while owner=DATA has no effect on the data transaction.
//  Data writes complete on mem_resp_valid (ack); d_rdata unchanged on stores.
//  mem_resp_valid outside WAIT is ignored. mem_ready outside ISSUE is ignored.
//  Watchdog: counter cleared on entering WAIT, +1 per WAIT cycle, saturates; reaching
//    TIMEOUT sets err (sticky until reset). FSM keeps waiting; no recovery action.
//  Reset asserted mid-transaction: immediate return to IDLE, outputs 0; memory is
//    reset by the same signal; any late response is discarded.
//  Requesters hold req and request fields stable until their done pulse.
// STRUCTURE
//  Package cpu_mem_pkg: arb_state_t {IDLE, ISSUE, WAIT}, owner_t {OWN_IF, OWN_D},
//    ADDR_W/DATA_W defaults shared with cpu top.
//  One sub-module: arb_watchdog (counter + sticky err, inputs clear/enable).
//  Request latch, FSM, stall logic stay in this module.
// TESTING
//  1 Reset: reset=0 mid-WAIT -> next edge state IDLE, mem_req=0, all done/stall-out 0, err=0.
//  2 Lone fetch if_addr=0x10, ready+resp immediate, mem_rdata=0x00500093 -> if_done 3 cycles after req, if_rdata=0x00500093.
//  3 Same-cycle if_req (0x20) and d_req load 0x100 -> mem_addr=0x100 first, d_done, then fetch 0x20; if_stall high throughout.
//  4 Store d_addr=0x104 d_wdata=0xDEADBEEF, mem_ready held low 5 cycles -> mem_req/fields stable 5 cycles, d_done on ack, d_rdata unchanged.
//  5 Fetch 0x30 in WAIT, if_flush pulsed -> no if_done, if_rdata unchanged, next fetch 0x40 completes normally.
//  6 TIMEOUT=8, mem_resp_valid withheld -> err rises after 8 WAIT cycles, stays 1 after late response completes.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU-to-unified-memory path.
// Used by the memory arbiter and the CPU top that instantiates it.
package cpu_mem_pkg;

    localparam int CPU_ADDR_W = 32;
    localparam int CPU_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_watchdog.sv
// Purpose: counts cycles spent waiting for a memory response; sticky err at TIMEOUT.
// Latency: err registers on the edge that completes the TIMEOUT-th counted cycle.
// Backpressure: none; observes only, never stalls or aborts the transaction.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err   <= 1'b0;
        end else begin
            if (clear) begin
                cnt_q <= '0;
            end else if (enable && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // err is set on the same edge the counter reaches TIMEOUT
            if (enable && cnt_q >= CNT_LAST) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Purpose: serialises IF fetches and MEM loads/stores onto one single-port memory.
// Latency: request seen in IDLE -> done pulse 3 cycles later with immediate ready/response.
// Backpressure: holds mem_req and fields until mem_ready; stalls requesters until their done.
module shared_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int DATA_W  = CPU_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              kill_q;
    logic              resp_fire;

    // A requester whose done is pulsing is not re-granted: that IDLE cycle is the bubble.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_req && !d_done) begin
                    grant   = 1'b1;
                    owner_d = OWN_D;
                end else if (if_req && !if_done && !if_flush) begin
                    grant   = 1'b1;
                    owner_d = OWN_IF;
                end
                if (grant) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: if (mem_ready) state_d = WAIT;
            WAIT:  if (mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            owner_q <= owner_d;
            we_q    <= (owner_d == OWN_D) && d_we;
            addr_q  <= (owner_d == OWN_D) ? d_addr : if_addr;
            wdata_q <= (owner_d == OWN_D) ? d_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kill_q <= 1'b0;
        end else if (state_q == IDLE) begin
            kill_q <= 1'b0;
        end else if (if_flush && owner_q == OWN_IF) begin
            kill_q <= 1'b1;
        end
    end

    assign resp_fire = (state_q == WAIT) && mem_resp_valid;

    // A flush landing on the response cycle itself also kills the fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_done  <= 1'b0;
            if_rdata <= '0;
            d_done   <= 1'b0;
            d_rdata  <= '0;
        end else begin
            if_done <= resp_fire && owner_q == OWN_IF && !kill_q && !if_flush;
            d_done  <= resp_fire && owner_q == OWN_D;
            if (resp_fire && owner_q == OWN_IF && !kill_q && !if_flush) begin
                if_rdata <= mem_rdata;
            end
            if (resp_fire && owner_q == OWN_D && !we_q) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_stall = if_req && !if_done;
    assign d_stall  = d_req && !d_done;

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear ((state_q == ISSUE) && mem_ready),
        .enable(state_q == WAIT),
        .err   (err)
    );

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: scripted memory responder plus scoreboard
// queues for memory requests and per-stage done/rdata.
module tb_shared_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_done, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_done, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err;

    always #5 clk = ~clk;

    shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .err(err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;

    mreq_t       exp_mem[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];

    int    checks = 0;
    int    errors = 0;
    int    rdy_delay = 0;
    int    rsp_delay = 0;
    bit    rsp_hold = 1'b0;
    int    m_st = 0;
    int    m_cnt = 0;
    mreq_t m_first;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h00500093;
            32'h20:  return 32'h00A00113;
            32'h30:  return 32'h00000013;
            32'h40:  return 32'h00208193;
            32'h100: return 32'h12345678;
            default: return 32'hBAD00000 ^ a;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event, expected none", nm);
    endtask

    task automatic accept();
        mreq_t e;
        mem_ready = 1'b1;
        if (exp_mem.size() == 0) begin
            unexpected("mem_accept");
        end else begin
            e = exp_mem.pop_front();
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_wdata", mem_wdata, e.wdata);
        end
        m_cnt = rsp_delay;
        m_st  = 2;
    endtask

    // Memory responder: ready after rdy_delay cycles, response rsp_delay cycles later.
    initial begin
        mem_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_resp_valid = 1'b0;
            if (!reset) begin
                m_st = 0;
            end else begin
                case (m_st)
                    0: if (mem_req) begin
                        m_first = '{mem_addr, mem_we, mem_wdata};
                        if (rdy_delay == 0) accept();
                        else begin
                            m_cnt = rdy_delay;
                            m_st  = 1;
                        end
                    end
                    1: begin
                        chk("mem_req_held", 32'(mem_req), 32'd1);
                        chk("mem_addr_stable", mem_addr, m_first.addr);
                        chk("mem_wdata_stable", mem_wdata, m_first.wdata);
                        m_cnt--;
                        if (m_cnt == 0) accept();
                    end
                    2: if (!rsp_hold) begin
                        if (m_cnt == 0) begin
                            mem_resp_valid = 1'b1;
                            mem_rdata = m_first.we ? 32'hA5A5A5A5 : mem_word(m_first.addr);
                            m_st = 0;
                        end else begin
                            m_cnt--;
                        end
                    end
                    default: m_st = 0;
                endcase
            end
        end
    end

    // Done monitor: every pulse must match the head of its stage's queue.
    always @(posedge clk) begin
        #1;
        if (if_done) begin
            if (exp_if.size() == 0) unexpected("if_done");
            else chk("if_rdata", if_rdata, exp_if.pop_front());
        end
        if (d_done) begin
            if (exp_d.size() == 0) unexpected("d_done");
            else chk("d_rdata", d_rdata, exp_d.pop_front());
        end
    end

    task automatic wait_done(input bit is_d, output int cyc);
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (is_d ? d_done : if_done) break;
            if (cyc >= 200) begin
                unexpected(is_d ? "d_done_timeout" : "if_done_timeout");
                break;
            end
        end
    endtask

    task automatic wait_accepted();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (m_st == 2) return;
        end
        unexpected("accept_timeout");
    endtask

    task automatic fetch(input logic [31:0] a, output int cyc);
        @(negedge clk);
        if_req = 1'b1;
        if_addr = a;
        exp_mem.push_back('{a, 1'b0, 32'h0});
        exp_if.push_back(mem_word(a));
        wait_done(1'b0, cyc);
        if_req = 1'b0;
    endtask

    initial begin
        int cyc;
        bit got_d;
        reset = 1'b0;
        if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_done", 32'(if_done), 0);
        chk("rst_d_done", 32'(d_done), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted while the fetch is waiting for its response
        rsp_hold = 1'b1;
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h10;
        exp_mem.push_back('{32'h10, 1'b0, 32'h0});
        wait_accepted();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        if_req = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 0);
        chk("midrst_if_done", 32'(if_done), 0);
        chk("midrst_d_done", 32'(d_done), 0);
        chk("midrst_if_stall", 32'(if_stall), 0);
        chk("midrst_d_stall", 32'(d_stall), 0);
        chk("midrst_err", 32'(err), 0);
        @(negedge clk);
        @(negedge clk);
        rsp_hold = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_idle", 32'(mem_req), 0);

        // Lone fetch, minimum latency
        fetch(32'h10, cyc);
        chk("fetch_latency", 32'(cyc), 3);
        chk("fetch_stall_on_done", 32'(if_stall), 0);

        // Simultaneous requests: data first
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        exp_mem.push_back('{32'h100, 1'b0, 32'h0});
        exp_mem.push_back('{32'h20, 1'b0, 32'h0});
        exp_d.push_back(32'h12345678);
        exp_if.push_back(32'h00A00113);
        got_d = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (if_done) break;
            chk("if_stall_held", 32'(if_stall), 1);
            if (d_done) begin
                got_d = 1'b1;
                d_req = 1'b0;
            end
        end
        chk("d_before_if", 32'(got_d), 1);
        if_req = 1'b0;

        // Store with memory not ready for 5 cycles
        rdy_delay = 5;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'hDEADBEEF;
        exp_mem.push_back('{32'h104, 1'b1, 32'hDEADBEEF});
        exp_d.push_back(32'h12345678);
        wait_done(1'b1, cyc);
        d_req = 1'b0;
        d_we = 1'b0;
        rdy_delay = 0;

        // Flushed fetch: no done, rdata untouched, next fetch normal
        rsp_delay = 3;
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h30;
        exp_mem.push_back('{32'h30, 1'b0, 32'h0});
        wait_accepted();
        @(negedge clk);
        if_flush = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("flush_if_rdata_kept", if_rdata, 32'h00A00113);
        chk("flush_no_refetch", 32'(mem_req), 0);
        rsp_delay = 0;
        fetch(32'h40, cyc);

        // Watchdog: response withheld past TIMEOUT
        rsp_hold = 1'b1;
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h10;
        exp_mem.push_back('{32'h10, 1'b0, 32'h0});
        exp_if.push_back(32'h00500093);
        wait_accepted();
        chk("wd_err_start", 32'(err), 0);
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("wd_err_cycle%0d", k), 32'(err), (k >= TO) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        rsp_hold = 1'b0;
        wait_done(1'b0, cyc);
        if_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("wd_err_sticky", 32'(err), 1);

        repeat (5) @(posedge clk);
        #1;
        chk("mem_queue_drained", 32'(exp_mem.size()), 0);
        chk("if_queue_drained", 32'(exp_if.size()), 0);
        chk("d_queue_drained", 32'(exp_d.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
